// File: rtl/multicycle_control_if.sv
// Instruction and data bus handshake between the multicycle control FSM
// and the memory side. The controller is the master: it raises a request
// and holds it until the matching ack; an ack may arrive in the same cycle
// as the request. data_we is meaningful only while data_req is high.
interface multicycle_control_if;
    logic inst_req;
    logic inst_ack;
    logic data_req;
    logic data_we;
    logic data_ack;

    modport master (
        output inst_req,
        output data_req,
        output data_we,
        input  inst_ack,
        input  data_ack
    );

    modport slave (
        input  inst_req,
        input  data_req,
        input  data_we,
        output inst_ack,
        output data_ack
    );
endinterface

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle core: FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB).
// Drives the instruction/data bus handshakes and all datapath write strobes.
// Handshake: a request stays high until its ack; the ack cycle completes the
// transfer. With BUS_TIMEOUT > 0 an unanswered request is abandoned after
// BUS_TIMEOUT wait cycles, bus_error pulses and the same PC is refetched.
// Optional feature macro: TRAP_ILLEGAL_EN (unknown opcode locks in TRAP
// until reset); when undefined an unknown opcode retires as a NOP.

`ifndef OPCODE_LOAD
`define OPCODE_LOAD     7'b0000011
`define OPCODE_LOAD_FP  7'b0000111
`define OPCODE_MISC_MEM 7'b0001111
`define OPCODE_OP_IMM   7'b0010011
`define OPCODE_AUIPC    7'b0010111
`define OPCODE_STORE    7'b0100011
`define OPCODE_STORE_FP 7'b0100111
`define OPCODE_OP       7'b0110011
`define OPCODE_LUI      7'b0110111
`define OPCODE_BRANCH   7'b1100011
`define OPCODE_JALR     7'b1100111
`define OPCODE_JAL      7'b1101111
`define OPCODE_SYSTEM   7'b1110011
`endif

module multicycle_control #(
    parameter int BUS_TIMEOUT = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    multicycle_control_if.master bus,
    input  logic [6:0]           opcode,
    input  logic                 branch_taken,
    output logic                 ir_write,
    output logic                 imm_write,
    output logic                 alu_a_sel,
    output logic                 alu_b_sel,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic                 pc_write,
    output logic [1:0]           pc_source,
    output logic                 bus_error,
    output logic                 illegal_inst,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    localparam int CW = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_VAL = CW'(BUS_TIMEOUT);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic          wait_expired;

    logic is_load;
    logic is_store;
    logic is_mem;
    logic is_jump;
    logic is_wb_op;
    logic is_known;

    logic inst_req_o;
    logic data_req_o;
    logic data_we_o;

    // Opcode classes; IR is stable from DECODE onward so the live opcode is used.
    always_comb begin
        is_load  = (opcode == `OPCODE_LOAD)  || (opcode == `OPCODE_LOAD_FP);
        is_store = (opcode == `OPCODE_STORE) || (opcode == `OPCODE_STORE_FP);
        is_mem   = is_load || is_store;
        is_jump  = (opcode == `OPCODE_JAL)   || (opcode == `OPCODE_JALR);
        is_wb_op = (opcode == `OPCODE_OP)    || (opcode == `OPCODE_OP_IMM) ||
                   (opcode == `OPCODE_LUI)   || (opcode == `OPCODE_AUIPC)  || is_jump;
        is_known = is_mem || is_wb_op || (opcode == `OPCODE_BRANCH) ||
                   (opcode == `OPCODE_MISC_MEM) || (opcode == `OPCODE_SYSTEM);
    end

    // Expiry only counts when the ack is absent: an ack in the expiry cycle wins.
    always_comb begin
        wait_expired = 1'b0;
        if (BUS_TIMEOUT > 0 && wait_cnt == TMO_VAL) begin
            if (state == S_FETCH && !bus.inst_ack) wait_expired = 1'b1;
            if (state == S_MEM   && !bus.data_ack) wait_expired = 1'b1;
        end
    end

    // State register; reset overrides any ack seen in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Bus wait counter: restarts on every state change or refetch, counts idle wait cycles.
    always_ff @(posedge clock) begin
        if (reset || wait_expired || state_next != state) begin
            wait_cnt <= '0;
        end else if (BUS_TIMEOUT > 0 && (state == S_FETCH || state == S_MEM)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (bus.inst_ack)      state_next = S_DECODE;
                else if (wait_expired) state_next = S_FETCH;
            end
            S_DECODE: begin
`ifdef TRAP_ILLEGAL_EN
                state_next = is_known ? S_EXECUTE : S_TRAP;
`else
                state_next = S_EXECUTE;
`endif
            end
            S_EXECUTE: begin
                if (is_mem)        state_next = S_MEM;
                else if (is_wb_op) state_next = S_WB;
                else               state_next = S_FETCH;
            end
            S_MEM: begin
                if (bus.data_ack)      state_next = is_store ? S_FETCH : S_WB;
                else if (wait_expired) state_next = S_FETCH;
            end
            S_WB:    state_next = S_FETCH;
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    // Output decode; everything is forced low while reset is high.
    always_comb begin
        inst_req_o   = 1'b0;
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        ir_write     = 1'b0;
        imm_write    = 1'b0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 2'd0;
        pc_write     = 1'b0;
        pc_source    = 2'd0;
        bus_error    = 1'b0;
        illegal_inst = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    inst_req_o = !wait_expired;
                    ir_write   = bus.inst_ack;
                    bus_error  = wait_expired;
                end
                S_DECODE: imm_write = 1'b1;
                S_EXECUTE: begin
                    if (is_mem) begin
                        alu_b_sel = 1'b1;
                    end else if (opcode == `OPCODE_OP) begin
                        alu_b_sel = 1'b0;
                    end else if (opcode == `OPCODE_OP_IMM || opcode == `OPCODE_LUI) begin
                        alu_b_sel = 1'b1;
                    end else if (opcode == `OPCODE_AUIPC) begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                    end else if (opcode == `OPCODE_JAL) begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                        pc_write  = 1'b1;
                        pc_source = 2'd1;
                    end else if (opcode == `OPCODE_JALR) begin
                        alu_b_sel = 1'b1;
                        pc_write  = 1'b1;
                        pc_source = 2'd2;
                    end else if (opcode == `OPCODE_BRANCH) begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                        pc_write  = 1'b1;
                        pc_source = branch_taken ? 2'd1 : 2'd0;
                    end else begin
                        // MISC_MEM, SYSTEM and unknown opcodes retire as NOPs.
                        pc_write  = 1'b1;
                    end
                end
                S_MEM: begin
                    data_req_o = !wait_expired;
                    data_we_o  = is_store && !wait_expired;
                    bus_error  = wait_expired;
                    pc_write   = is_store && bus.data_ack;
                end
                S_WB: begin
                    reg_write = 1'b1;
                    if (is_jump) begin
                        wb_sel = 2'd2;
                    end else begin
                        wb_sel   = is_load ? 2'd1 : 2'd0;
                        pc_write = 1'b1;
                    end
                end
                S_TRAP: begin
`ifdef TRAP_ILLEGAL_EN
                    illegal_inst = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.inst_req = inst_req_o;
    assign bus.data_req = data_req_o;
    assign bus.data_we  = data_we_o;
    assign state_dbg    = state;

endmodule
